// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, requests instruction memory and presents the word to decode in an IR.
// Latency: IrValid rises one edge after ImemAck; zero-wait memory gives one instruction per two cycles.
// Backpressure: with DecReady low the IR and all outputs hold and no request is issued; Redirect overrides.
// Optional: define FETCH_STALL_CNT_EN to add the saturating StallCount output.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_STEP  = 2
) (
  input  logic        Clock,
  input  logic        Reset_n,
  output logic        ImemReq,
  output logic [15:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [15:0] ImemData,
  input  logic        Redirect,
  input  logic [15:0] RedirectPc,
  output logic        IrValid,
  input  logic        DecReady,
  output logic [15:0] IrData,
  output logic [3:0]  IrOpcode,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0] StallCount,
`endif
  output logic [15:0] IrPc
);

  localparam logic [15:0] PcStep = 16'(PC_STEP);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_data_q, ir_data_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;

  // Next-state: redirect wins over ack and decode handshake; ack captures the word and advances the PC.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_data_d  = ir_data_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    if (Redirect) begin
      pc_d       = RedirectPc & 16'hFFFE;
      ir_valid_d = 1'b0;
      state_d    = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (ImemAck) begin
            ir_data_d  = ImemData;
            ir_pc_d    = pc_q;
            pc_d       = pc_q + PcStep;
            ir_valid_d = 1'b1;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (DecReady) begin
            ir_valid_d = 1'b0;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // FSM and datapath registers, cleared asynchronously.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      ir_data_q  <= 16'h0000;
      ir_pc_q    <= 16'h0000;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_data_q  <= ir_data_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // Request is gated by reset so memory sees no request while the unit is held in reset,
  // yet the first request appears in the very first cycle after release.
  assign ImemReq  = (state_q == FETCH) && Reset_n;
  assign ImemAddr = pc_q;
  assign IrValid  = ir_valid_q;
  assign IrData   = ir_data_q;
  assign IrPc     = ir_pc_q;
  assign IrOpcode = ir_data_q[15:12];

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where decode refuses a valid instruction; saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ir_valid_q && !DecReady && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register; only reset clears it, redirects do not.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a scoreboard of expected IR contents.
// Expected words are queued when memory acks and compared when the IR becomes valid.
// A second instance built with RESET_PC=16'hFFFE covers PC wrap-around.
module tb_instruction_fetch_unit;

  typedef struct {
    logic [15:0] data;
    logic [15:0] pc;
  } exp_t;

  logic        Clock;
  logic        Reset_n;
  logic        ImemReq;
  logic [15:0] ImemAddr;
  logic        ImemAck;
  logic [15:0] ImemData;
  logic        Redirect;
  logic [15:0] RedirectPc;
  logic        IrValid;
  logic        DecReady;
  logic [15:0] IrData;
  logic [3:0]  IrOpcode;
  logic [15:0] IrPc;

  logic        w_req;
  logic [15:0] w_addr;
  logic        w_ack;
  logic [15:0] w_data_in;
  logic        w_valid;
  logic        w_dec;
  logic [15:0] w_ir;
  logic [3:0]  w_op;
  logic [15:0] w_pc;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] StallCount;
  logic [15:0] w_stall;
`endif

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];
  logic [15:0] mpc;
  logic [15:0] hold_dat;
  logic [15:0] hold_pc;

  instruction_fetch_unit u_dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemAck    (ImemAck),
    .ImemData   (ImemData),
    .Redirect   (Redirect),
    .RedirectPc (RedirectPc),
    .IrValid    (IrValid),
    .DecReady   (DecReady),
    .IrData     (IrData),
    .IrOpcode   (IrOpcode),
`ifdef FETCH_STALL_CNT_EN
    .StallCount (StallCount),
`endif
    .IrPc       (IrPc)
  );

  instruction_fetch_unit #(.RESET_PC(16'hFFFE), .PC_STEP(2)) u_dut_wrap (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .ImemReq    (w_req),
    .ImemAddr   (w_addr),
    .ImemAck    (w_ack),
    .ImemData   (w_data_in),
    .Redirect   (1'b0),
    .RedirectPc (16'h0000),
    .IrValid    (w_valid),
    .DecReady   (w_dec),
    .IrData     (w_ir),
    .IrOpcode   (w_op),
`ifdef FETCH_STALL_CNT_EN
    .StallCount (w_stall),
`endif
    .IrPc       (w_pc)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_vld"}, {15'd0, IrValid}, 16'd1);
    check({tag, "_sb_nonempty"}, {15'd0, (sb.size() != 0)}, 16'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, IrData, e.data);
      check({tag, "_pc"}, IrPc, e.pc);
      check({tag, "_op"}, {12'd0, IrOpcode}, {12'd0, e.data[15:12]});
    end
  endtask

  // Request held for `waits` cycles before the ack; then checks the captured IR.
  task automatic do_fetch(input logic [15:0] data, input int waits, input string tag);
    exp_t e;
    for (int i = 0; i <= waits; i++) begin
      check({tag, "_req"}, {15'd0, ImemReq}, 16'd1);
      check({tag, "_addr"}, ImemAddr, mpc);
      check({tag, "_vld_lo"}, {15'd0, IrValid}, 16'd0);
      if (i < waits) tick();
    end
    ImemAck  = 1'b1;
    ImemData = data;
    e.data   = data;
    e.pc     = mpc;
    sb.push_back(e);
    tick();
    ImemAck  = 1'b0;
    ImemData = 16'h0000;
    mpc      = mpc + 16'd2;
    pop_check(tag);
    check({tag, "_req_hold"}, {15'd0, ImemReq}, 16'd0);
  endtask

  initial begin
    Reset_n    = 1'b0;
    ImemAck    = 1'b0;
    ImemData   = 16'h0000;
    Redirect   = 1'b0;
    RedirectPc = 16'h0000;
    DecReady   = 1'b0;
    w_ack      = 1'b0;
    w_data_in  = 16'h0000;
    w_dec      = 1'b0;
    mpc        = 16'h0000;

    // Reset state
    tick();
    tick();
    check("rst_req", {15'd0, ImemReq}, 16'd0);
    check("rst_vld", {15'd0, IrValid}, 16'd0);
    check("rst_ir", IrData, 16'h0000);
    check("rst_irpc", IrPc, 16'h0000);
    check("rst_addr", ImemAddr, 16'h0000);
    check("rst_wreq", {15'd0, w_req}, 16'd0);
`ifdef FETCH_STALL_CNT_EN
    check("rst_stall", StallCount, 16'h0000);
`endif

    // Release: request in the first cycle
    Reset_n  = 1'b1;
    DecReady = 1'b1;
    w_dec    = 1'b1;
    #1;
    check("rel_req", {15'd0, ImemReq}, 16'd1);
    check("rel_addr", ImemAddr, 16'h0000);
    check("wrap_req", {15'd0, w_req}, 16'd1);
    check("wrap_addr0", w_addr, 16'hFFFE);
    @(negedge Clock);

    // Wrap instance: fetch at 0xFFFE, next at 0x0000
    w_ack     = 1'b1;
    w_data_in = 16'hA5A5;
    tick();
    w_ack     = 1'b0;
    w_data_in = 16'h0000;
    check("wrap_vld", {15'd0, w_valid}, 16'd1);
    check("wrap_ir", w_ir, 16'hA5A5);
    check("wrap_op", {12'd0, w_op}, 16'h000A);
    check("wrap_irpc", w_pc, 16'hFFFE);
    tick();
    check("wrap_addr1", w_addr, 16'h0000);
    check("wrap_req1", {15'd0, w_req}, 16'd1);

    // Zero-wait back-to-back fetches
    do_fetch(16'h1234, 0, "zw0");
    tick();
    check("zw0_vld_drop", {15'd0, IrValid}, 16'd0);
    do_fetch(16'hC456, 0, "zw1");
    check("zw1_opcode", {12'd0, IrOpcode}, 16'h000C);
    tick();
    check("zw1_vld_drop", {15'd0, IrValid}, 16'd0);
    check("zw1_next_addr", ImemAddr, 16'h0004);

    // Wait-stated memory: ack three cycles after the request
    do_fetch(16'h5A5A, 3, "ws");
    tick();
    check("ws_next_addr", ImemAddr, mpc);

    // Decode stall for five cycles
    DecReady = 1'b0;
    do_fetch(16'h7001, 0, "st");
    hold_dat = IrData;
    hold_pc  = IrPc;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("st_ir", IrData, 16'h7001);
      check("st_irpc", IrPc, hold_pc);
      check("st_req", {15'd0, ImemReq}, 16'd0);
      check("st_vld", {15'd0, IrValid}, 16'd1);
    end
    check("st_ir_same", IrData, hold_dat);
`ifdef FETCH_STALL_CNT_EN
    check("st_count", StallCount, 16'd5);
`endif
    DecReady = 1'b1;
    tick();
    check("st_release", {15'd0, IrValid}, 16'd0);

    // Redirect in the same cycle as ack: data dropped, PC reloaded with bit 0 cleared
    ImemAck    = 1'b1;
    ImemData   = 16'hBEEF;
    Redirect   = 1'b1;
    RedirectPc = 16'h0041;
    tick();
    ImemAck  = 1'b0;
    ImemData = 16'h0000;
    Redirect = 1'b0;
    mpc      = 16'h0040;
    check("rd_ack_vld", {15'd0, IrValid}, 16'd0);
    check("rd_ack_req", {15'd0, ImemReq}, 16'd1);
    check("rd_ack_addr", ImemAddr, 16'h0040);
    do_fetch(16'h2222, 0, "rd_ack_f");
    tick();

    // Redirect abandons a pending request
    tick();
    check("rd_pend_req", {15'd0, ImemReq}, 16'd1);
    Redirect   = 1'b1;
    RedirectPc = 16'h1000;
    tick();
    Redirect = 1'b0;
    mpc      = 16'h1000;
    do_fetch(16'h3333, 1, "rd_pend_f");
    tick();

    // Redirect while holding a stalled instruction
    DecReady = 1'b0;
    do_fetch(16'h4444, 0, "rd_hold_f");
    Redirect   = 1'b1;
    RedirectPc = 16'h2003;
    tick();
    Redirect = 1'b0;
    DecReady = 1'b1;
    mpc      = 16'h2002;
    check("rd_hold_vld", {15'd0, IrValid}, 16'd0);
    check("rd_hold_addr", ImemAddr, 16'h2002);
`ifdef FETCH_STALL_CNT_EN
    check("rd_hold_count", StallCount, 16'd6);
`endif

    // Asynchronous reset during a wait-stated request
    tick();
    check("ar_wait_req_pre", {15'd0, ImemReq}, 16'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("ar_wait_req", {15'd0, ImemReq}, 16'd0);
    check("ar_wait_vld", {15'd0, IrValid}, 16'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    mpc     = 16'h0000;
    #1;
    check("ar_rel_req", {15'd0, ImemReq}, 16'd1);
    check("ar_rel_addr", ImemAddr, 16'h0000);
    @(negedge Clock);

    // Asynchronous reset while the IR holds a valid word
    DecReady = 1'b0;
    do_fetch(16'h6789, 0, "ar_hold_f");
    #2 Reset_n = 1'b0;
    #1;
    check("ar_hold_vld", {15'd0, IrValid}, 16'd0);
    check("ar_hold_ir", IrData, 16'h0000);
    check("ar_hold_req", {15'd0, ImemReq}, 16'd0);
`ifdef FETCH_STALL_CNT_EN
    check("ar_hold_count", StallCount, 16'd0);
`endif
    @(negedge Clock);
    Reset_n  = 1'b1;
    DecReady = 1'b1;
    mpc      = 16'h0000;
    #1;
    check("ar2_rel_addr", ImemAddr, 16'h0000);
    @(negedge Clock);
    do_fetch(16'h1111, 0, "ar2_f");
    tick();

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage of the 16-bit CPU. It sits directly upstream of Control_Unit.
- Holds the PC and issues requests to instruction memory.
- Captures the returned 16-bit word into an instruction register.
- Presents the word to decode with a valid/ready handshake; IrOpcode drives Control_Unit.OPCode.
- Accepts a branch redirect, which flushes the stage and reloads the PC.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 2, PC increment per accepted fetch (byte-addressed, 16-bit words)

Ports:
Clock  input  1  rising-edge clock
Reset_n  input  1  asynchronous, active-low reset
ImemReq  output  1  fetch request to instruction memory
ImemAddr  output  16  fetch address (equals current PC)
ImemAck  input  1  memory returns ImemData for the ImemAddr presented this cycle
ImemData  input  16  instruction word
Redirect  input  1  branch taken; flush and load RedirectPc
RedirectPc  input  16  branch target; bit 0 forced to 0
IrValid  output  1  instruction register holds a valid instruction
DecReady  input  1  decode accepts the instruction this cycle
IrData  output  16  instruction register
IrOpcode  output  4  IrData[15:12], feeds Control_Unit
IrPc  output  16  address the instruction in IrData was fetched from

Behaviour:
- Reset (Reset_n low, asynchronous; takes effect immediately):
  - PC=RESET_PC, IrData=0, IrPc=0, IrValid=0, state=FETCH.
  - ImemReq must be 0 while Reset_n is low.
  - First request is issued in the first cycle after release.
- States:
  - FETCH: ImemReq=1, ImemAddr=PC. Held until ImemAck; any number of wait cycles is allowed.
  - HOLD: IrValid=1, ImemReq=0.
- FETCH with ImemAck and no Redirect, at the next edge:
  - IrData<=ImemData, IrPc<=PC, PC<=PC+PC_STEP (mod 2^16).
  - IrValid<=1, state<=HOLD.
- HOLD with DecReady and no Redirect: IrValid<=0, state<=FETCH at the next edge.
- HOLD without DecReady: all outputs held stable, no new request.
- Throughput and latency:
  - Zero-wait memory (ack in the request cycle) gives 1 instruction per 2 cycles.
  - Latency from request to IrValid is 1 edge after ImemAck.
- Redirect, any state:
  - At the next edge: PC<=RedirectPc & 16'hFFFE, IrValid<=0, state<=FETCH.
  - Redirect has priority over ImemAck and DecReady. Same-cycle fetched data is discarded and the PC does not increment.
  - A request pending without ack is abandoned. The next request uses the new address.
- Wrap-around: PC=16'hFFFE plus PC_STEP gives 16'h0000, with no flag.
- IrOpcode is combinational from IrData and is valid only when IrValid=1.
- The unit never changes IrData while IrValid=1 unless Redirect is asserted.

Optional Feature:
Macro FETCH_STALL_CNT_EN.
- When defined, adds output StallCount [15:0]:
  - Increments each cycle with IrValid=1 and DecReady=0.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by reset.
  - Not cleared by Redirect.
- When undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset then release with zero-wait memory, DecReady=1, memory words 0x1234 @0, 0xC456 @2 -> ImemAddr 0x0000 then 0x0002; IrData 0x1234 with IrPc 0x0000, then 0xC456 with IrOpcode 4'b1100; IrValid pulses every second cycle.
- Memory acks 3 cycles after request -> ImemReq and ImemAddr stable for 4 cycles; IrValid rises 1 edge after ack; PC increments once.
- DecReady=0 for 5 cycles with IrValid=1 -> IrData and IrPc unchanged, ImemReq=0; with FETCH_STALL_CNT_EN, StallCount reaches 5.
- Redirect=1 with RedirectPc=0x0041 in the same cycle as ImemAck -> data discarded, IrValid=0; next ImemAddr=0x0040.
- RESET_PC=16'hFFFE -> first fetch at 0xFFFE, second at 0x0000.
- Reset_n pulled low during a wait-stated request -> ImemReq=0 and IrValid=0 immediately, without waiting for a clock edge; after release a fetch is issued at RESET_PC.
